// File: rtl/blinky_pkg.sv
// Shared types for the multi-channel LED blinker: mode encoding,
// per-channel configuration record and the mode decode helper.
package blinky_pkg;

  // Channel counters are held at this width internally; port-side CntWidth
  // values are zero-extended into it, so CntWidth must not exceed 32.
  localparam int unsigned MaxCntWidth = 32;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_PWM   = 3'd3,
    MODE_BURST = 3'd4
  } mode_e;

  typedef struct packed {
    mode_e                  mode;
    logic [MaxCntWidth-1:0] period;
    logic [MaxCntWidth-1:0] duty;
  } chan_cfg_t;

  // Reserved codes 5..7 fall back to OFF.
  function automatic mode_e decode_mode(input logic [2:0] code);
    case (code)
      3'd1:    return MODE_ON;
      3'd2:    return MODE_BLINK;
      3'd3:    return MODE_PWM;
      3'd4:    return MODE_BURST;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: holds its configuration, phase counter and burst count,
// and produces a registered LED level plus a one-cycle burst-done pulse.
module blinky_channel
  import blinky_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      tick_i,
  input  logic      sync_i,
  input  logic      wr_i,
  input  chan_cfg_t cfg_i,
  output logic      led_o,
  output logic      done_o
);

  chan_cfg_t              cfg_q;
  logic [MaxCntWidth-1:0] phase_q;
  logic [MaxCntWidth-1:0] bcnt_q;
  logic                   led_q;
  logic                   done_q;

  logic [MaxCntWidth-1:0] last_phase;
  logic                   phase_wrap;
  logic [MaxCntWidth-1:0] phase_nxt;

  // Phase wrap point; a period of 0 behaves as a period of 1.
  always_comb begin
    last_phase = '0;
    if (cfg_q.period != '0) begin
      last_phase = cfg_q.period - MaxCntWidth'(1);
    end
    phase_wrap = (phase_q == last_phase);
    phase_nxt  = phase_wrap ? '0 : phase_q + MaxCntWidth'(1);
  end

  // Channel state: a config write beats sync, which beats normal tick work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q.mode   <= MODE_OFF;
      cfg_q.period <= MaxCntWidth'(1);
      cfg_q.duty   <= '0;
      phase_q      <= '0;
      bcnt_q       <= '0;
      led_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_i) begin
        cfg_q   <= cfg_i;
        phase_q <= '0;
        bcnt_q  <= '0;
        led_q   <= 1'b0;
      end else if (sync_i) begin
        phase_q <= '0;
        bcnt_q  <= '0;
        led_q   <= 1'b0;
      end else begin
        case (cfg_q.mode)
          MODE_ON: led_q <= 1'b1;
          MODE_BLINK: begin
            if (tick_i) begin
              phase_q <= phase_nxt;
              if (phase_wrap) begin
                led_q <= ~led_q;
              end
            end
          end
          MODE_PWM: begin
            if (tick_i) begin
              phase_q <= phase_nxt;
              led_q   <= (phase_q < cfg_q.duty);
            end
          end
          MODE_BURST: begin
            if (tick_i) begin
              if (cfg_q.duty == '0) begin
                cfg_q.mode <= MODE_OFF;
                led_q      <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                phase_q <= phase_nxt;
                if (phase_wrap) begin
                  if (!led_q) begin
                    led_q <= 1'b1;
                  end else if (bcnt_q + MaxCntWidth'(1) == cfg_q.duty) begin
                    // Final falling edge: LED off, done pulse, channel parks in OFF.
                    cfg_q.mode <= MODE_OFF;
                    led_q      <= 1'b0;
                    done_q     <= 1'b1;
                    bcnt_q     <= '0;
                  end else begin
                    led_q  <= 1'b0;
                    bcnt_q <= bcnt_q + MaxCntWidth'(1);
                  end
                end
              end
            end
          end
          default: led_q <= 1'b0;
        endcase
      end
    end
  end

  assign led_o  = led_q;
  assign done_o = done_q;

endmodule

// File: rtl/blinky_multi.sv
// Multi-channel LED blinker: shared tick prescaler, valid/ready config
// write port and an array of independently configured LED channels.
module blinky_multi
  import blinky_pkg::*;
#(
  parameter  int unsigned NumChannels   = 4,
  parameter  int unsigned CyclesPerTick = 100,
  parameter  int unsigned CntWidth      = 8,
  localparam int unsigned ChanWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sync_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [ChanWidth-1:0]   cfg_chan_i,
  input  logic [2:0]             cfg_mode_i,
  input  logic [CntWidth-1:0]    cfg_period_i,
  input  logic [CntWidth-1:0]    cfg_duty_i,
  output logic [NumChannels-1:0] led_o,
  output logic [NumChannels-1:0] done_o
);

  localparam int unsigned PreWidth = (CyclesPerTick > 1) ? $clog2(CyclesPerTick) : 1;

  logic [PreWidth-1:0] pre_q;
  logic                tick;
  logic                ready_q;
  logic                accept;
  chan_cfg_t           wr_cfg;

  assign tick = (pre_q == PreWidth'(CyclesPerTick - 1));

  // Prescaler: counts 0..CyclesPerTick-1, restarted by sync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else if (sync_i || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Config port is ready from the first edge after reset release onwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign cfg_ready_o = ready_q;
  assign accept      = cfg_valid_i && ready_q;

  assign wr_cfg = '{
    mode:   decode_mode(cfg_mode_i),
    period: MaxCntWidth'(cfg_period_i),
    duty:   MaxCntWidth'(cfg_duty_i)
  };

  // Out-of-range channel indices match no instance, so the write is dropped.
  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    logic wr;
    assign wr = accept && (cfg_chan_i == ChanWidth'(g));

    blinky_channel u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_i (tick),
      .sync_i (sync_i),
      .wr_i   (wr),
      .cfg_i  (wr_cfg),
      .led_o  (led_o[g]),
      .done_o (done_o[g])
    );
  end

endmodule
